instr_fetch_unit: RTL and testbench

Upstream fetch stage for the register-file/ALU datapath. Holds the program counter and reads 16-bit CR16A instructions from a synchronous instruction memory with 1-cycle read latency. Latches each word into an instruction register and presents it to the datapath with a valid/ready handshake. Accepts PC redirects for branches and jumps from the datapath.

---
 rtl/instr_fetch_unit.sv | 96 +++++++++
 tb/tb_instr_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, 1-cycle-latency instruction memory read, instruction register with valid/ready.
// Handshake to next instr_valid is 3 cycles; without instr_ready the word is held and no new fetch issues.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [15:0]           mem_rdata,
  output logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           fetch_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [15:0]           instr_q, instr_d;
  logic [15:0]           fetch_count_q, fetch_count_d;
  logic                  handshake;

  assign handshake = (state_q == HOLD) && instr_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      IDLE:  if (enable) state_d = READ;
      READ:  state_d = LATCH;
      LATCH: begin
        instr_d    = mem_rdata;
        instr_pc_d = pc_q;
        pc_d       = pc_q + ADDR_WIDTH'(1);
        state_d    = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          fetch_count_d = fetch_count_q + 16'd1;
          state_d       = enable ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect discards any word in flight and refetches from the target;
    // a handshake in the same HOLD cycle still counts as delivered.
    if (pc_load) begin
      pc_d       = pc_load_addr;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      if (state_q != IDLE) state_d = READ;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      instr_pc_q    <= RESET_PC;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign mem_rd_en   = (state_q == READ);
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for reset/sequential fetch, directed corner sequences,
// then random enable/ready/redirect traffic against a delivered-stream reference model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic [15:0] pc;
  logic [15:0] fetch_count;

  int checks = 0;
  int fails  = 0;

  instr_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc(pc), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Synchronous instruction memory with one-cycle read latency
  initial mem_rdata = 16'h0000;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_word(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: in-order delivered stream. Each handshake delivers the next
  // program-order address; any redirect makes the target the next address delivered.
  logic [15:0] exp_pc  = 16'h0000;
  logic [15:0] exp_cnt = 16'h0000;
  int          hs_total = 0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_pc  = 16'h0000;
      exp_cnt = 16'h0000;
    end else begin
      chk("model_mem_addr", {16'h0, mem_addr}, {16'h0, pc});
      chk("model_fetch_count", {16'h0, fetch_count}, {16'h0, exp_cnt});
      if (instr_valid && instr_ready) begin
        chk("model_instr_pc", {16'h0, instr_pc}, {16'h0, exp_pc});
        chk("model_instr", {16'h0, instr}, {16'h0, mem_word(exp_pc)});
        exp_pc  = exp_pc + 16'd1;
        exp_cnt = exp_cnt + 16'd1;
        hs_total++;
      end
      if (pc_load) exp_pc = pc_load_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, {31'h0, instr_valid}, 32'h1);
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic        rd;
    logic        vld;
    logic [15:0] ins;
    logic [15:0] ipc;
    logic [15:0] npc;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int hs_before;
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5, 16'h0, 16'h1, 16'h0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA5A5, 16'h0, 16'h1, 16'h1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h0, 16'h1, 16'h1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A4, 16'h1, 16'h2, 16'h1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA5A4, 16'h1, 16'h2, 16'h2};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA5A4, 16'h1, 16'h2, 16'h2};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A7, 16'h2, 16'h3, 16'h2};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA5A7, 16'h2, 16'h3, 16'h3};

    reset = 1'b0; enable = 1'b1; instr_ready = 1'b1; pc_load = 1'b0; pc_load_addr = 16'h0;

    // Reset values and sequential fetch, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst; enable = vecs[i].en; instr_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("t1_row%0d_rd_en", i), {31'h0, mem_rd_en}, {31'h0, vecs[i].rd});
      chk($sformatf("t1_row%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].vld});
      chk($sformatf("t1_row%0d_instr", i), {16'h0, instr}, {16'h0, vecs[i].ins});
      chk($sformatf("t1_row%0d_instr_pc", i), {16'h0, instr_pc}, {16'h0, vecs[i].ipc});
      chk($sformatf("t1_row%0d_pc", i), {16'h0, pc}, {16'h0, vecs[i].npc});
      chk($sformatf("t1_row%0d_count", i), {16'h0, fetch_count}, {16'h0, vecs[i].cnt});
      tick();
    end

    // Backpressure: word at address 3 held for 10 cycles
    instr_ready = 1'b0;
    wait_valid("t2_valid");
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_instr", {16'h0, instr}, 32'h0000A5A6);
      chk("t2_hold_instr_pc", {16'h0, instr_pc}, 32'h3);
      chk("t2_hold_rd_en", {31'h0, mem_rd_en}, 32'h0);
      chk("t2_hold_valid", {31'h0, instr_valid}, 32'h1);
      chk("t2_hold_count", {16'h0, fetch_count}, 32'h3);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t2_next_rd_en", {31'h0, mem_rd_en}, 32'h1);
    chk("t2_next_addr", {16'h0, mem_addr}, 32'h4);
    chk("t2_count", {16'h0, fetch_count}, 32'h4);

    // Redirect in HOLD without handshake
    wait_valid("t3a_valid");
    chk("t3a_held_pc", {16'h0, instr_pc}, 32'h4);
    pc_load = 1'b1; pc_load_addr = 16'h0040;
    tick();
    pc_load = 1'b0;
    chk("t3a_flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("t3a_count", {16'h0, fetch_count}, 32'h4);
    chk("t3a_rd_en", {31'h0, mem_rd_en}, 32'h1);
    chk("t3a_addr", {16'h0, mem_addr}, 32'h40);
    wait_valid("t3a_valid2");
    chk("t3a_instr", {16'h0, instr}, {16'h0, mem_word(16'h0040)});
    chk("t3a_instr_pc", {16'h0, instr_pc}, 32'h40);

    // Redirect in HOLD with handshake in the same cycle
    instr_ready = 1'b1; pc_load = 1'b1; pc_load_addr = 16'h0040;
    tick();
    instr_ready = 1'b0; pc_load = 1'b0;
    chk("t3b_count", {16'h0, fetch_count}, 32'h5);
    chk("t3b_rd_en", {31'h0, mem_rd_en}, 32'h1);
    chk("t3b_addr", {16'h0, mem_addr}, 32'h40);
    wait_valid("t3b_valid");
    chk("t3b_instr", {16'h0, instr}, {16'h0, mem_word(16'h0040)});
    chk("t3b_instr_pc", {16'h0, instr_pc}, 32'h40);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Redirect during LATCH, then again during READ
    tick();
    chk("t4_in_latch", {30'h0, mem_rd_en, instr_valid}, 32'h0);
    pc_load = 1'b1; pc_load_addr = 16'h0100;
    tick();
    chk("t4_read_rd_en", {31'h0, mem_rd_en}, 32'h1);
    chk("t4_read_addr", {16'h0, mem_addr}, 32'h100);
    tick();
    pc_load = 1'b0;
    chk("t4_reissue_rd_en", {31'h0, mem_rd_en}, 32'h1);
    chk("t4_reissue_addr", {16'h0, mem_addr}, 32'h100);
    wait_valid("t4_valid");
    chk("t4_instr_pc", {16'h0, instr_pc}, 32'h100);
    chk("t4_instr", {16'h0, instr}, {16'h0, mem_word(16'h0100)});
    chk("t4_pc", {16'h0, pc}, 32'h101);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // PC wrap-around
    pc_load = 1'b1; pc_load_addr = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    wait_valid("t5_valid1");
    chk("t5_instr_pc1", {16'h0, instr_pc}, 32'hFFFF);
    chk("t5_instr1", {16'h0, instr}, 32'h00005A5A);
    chk("t5_pc_wrapped", {16'h0, pc}, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_valid("t5_valid2");
    chk("t5_instr_pc2", {16'h0, instr_pc}, 32'h0);
    chk("t5_instr2", {16'h0, instr}, 32'h0000A5A5);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t5_count", {16'h0, fetch_count}, 32'h9);

    // Asynchronous reset during LATCH, release with enable low
    tick();
    chk("t6_in_latch", {30'h0, mem_rd_en, instr_valid}, 32'h0);
    reset = 1'b0; enable = 1'b0;
    #1;
    chk("t6_rst_pc", {16'h0, pc}, 32'h0);
    chk("t6_rst_instr", {16'h0, instr}, 32'h0);
    chk("t6_rst_instr_pc", {16'h0, instr_pc}, 32'h0);
    chk("t6_rst_count", {16'h0, fetch_count}, 32'h0);
    chk("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_idle_rd_en", {31'h0, mem_rd_en}, 32'h0);
      chk("t6_idle_valid", {31'h0, instr_valid}, 32'h0);
      chk("t6_idle_pc", {16'h0, pc}, 32'h0);
    end
    enable = 1'b1;
    wait_valid("t6_valid");
    chk("t6_instr_pc", {16'h0, instr_pc}, 32'h0);
    chk("t6_instr", {16'h0, instr}, 32'h0000A5A5);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t6_count", {16'h0, fetch_count}, 32'h1);

    // Random traffic against the stream model
    hs_before = hs_total;
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom_range(0, 7) != 0);
      instr_ready  = ($urandom_range(0, 2) != 0);
      pc_load      = ($urandom_range(0, 9) == 0);
      pc_load_addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1))
                                                 : 16'($urandom);
      tick();
    end
    pc_load = 1'b0;
    chk("rand_progress", {31'h0, (hs_total - hs_before) > 100}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
